// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: manual mode encoding
// and burst FSM state type.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BURST = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/usr_burst_fsm.sv
// Burst controller: runs a Count-long series of right shifts from one Start
// pulse, then raises Done for one enabled cycle.
module usr_burst_fsm
    import usr_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             shr,
    output logic             ovr,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             busy_nxt, done_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy_nxt  = busy;
        done_nxt  = done;
        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                done_nxt = 1'b0;
                if (start) begin
                    if (count != '0) begin
                        state_nxt = BURST;
                        cnt_nxt   = count;
                        busy_nxt  = 1'b1;
                    end else begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            BURST: begin
                cnt_nxt = cnt - 1'b1;
                // Last shift happens on this edge when one step remains.
                if (cnt <= 1) begin
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (en) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Mode is masked on the Start edge and throughout BURST and DONE.
    assign shr = en && (state == BURST);
    assign ovr = (state != IDLE) || start;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register (hold / shift right / shift left / load) with an
// autonomous right-shift burst. Define USR_ROTATE_EN to make bursts rotate.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             _Reset,
    input  logic             En,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SinL,
    input  logic             SinR,
    input  logic             Start,
    input  logic [CNT_W-1:0] Count,
    output logic [WIDTH-1:0] Q,
    output logic             SoutR,
    output logic             SoutL,
    output logic             Busy,
    output logic             Done
);

    logic             burst_shr;
    logic             mode_ovr;
    logic [WIDTH-1:0] q_nxt;
    logic             burst_fill;

    usr_burst_fsm #(
        .CNT_W (CNT_W)
    ) u_fsm (
        .clk   (Clk),
        .rst_n (_Reset),
        .en    (En),
        .start (Start),
        .count (Count),
        .shr   (burst_shr),
        .ovr   (mode_ovr),
        .busy  (Busy),
        .done  (Done)
    );

`ifdef USR_ROTATE_EN
    assign burst_fill = Q[0];
`else
    assign burst_fill = SinL;
`endif

    always_comb begin
        q_nxt = Q;
        if (burst_shr) begin
            q_nxt = {burst_fill, Q[WIDTH-1:1]};
        end else if (!mode_ovr) begin
            case (Mode)
                MODE_SHR:  q_nxt = {SinL, Q[WIDTH-1:1]};
                MODE_SHL:  q_nxt = {Q[WIDTH-2:0], SinR};
                MODE_LOAD: q_nxt = D;
                default:   q_nxt = Q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!_Reset) begin
            Q <= '0;
        end else if (En) begin
            Q <= q_nxt;
        end
    end

    assign SoutR = Q[0];
    assign SoutL = Q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8); burst expectations follow
// whether USR_ROTATE_EN is defined for the build.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst_n, en, sinl, sinr, start;
    logic [1:0] mode;
    logic [7:0] d;
    logic [3:0] count;
    logic [7:0] q;
    logic       soutr, soutl, busy, done;

    typedef struct {
        bit         chk;
        logic [7:0] q;
        logic       busy;
        logic       done;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    univ_shift_reg #(.WIDTH(8)) dut (
        .Clk    (clk),
        ._Reset (rst_n),
        .En     (en),
        .Mode   (mode),
        .D      (d),
        .SinL   (sinl),
        .SinR   (sinr),
        .Start  (start),
        .Count  (count),
        .Q      (q),
        .SoutR  (soutr),
        .SoutL  (soutl),
        .Busy   (busy),
        .Done   (done)
    );

    always #5 clk = ~clk;

    // Monitor: one expectation per clock, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [11:0] act, req;
            e = exp_q.pop_front();
            if (e.chk) begin
                act = {q, soutl, soutr, busy, done};
                req = {e.q, e.q[7], e.q[0], e.busy, e.done};
                n_cmp++;
                if (act !== req) begin
                    n_bad++;
                    $display("FAIL %s: got q=%h soutl=%b soutr=%b busy=%b done=%b, want q=%h soutl=%b soutr=%b busy=%b done=%b",
                             e.nm, q, soutl, soutr, busy, done,
                             e.q, e.q[7], e.q[0], e.busy, e.done);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic i_en, input logic i_rst, input logic [1:0] i_mode,
                        input logic [7:0] i_d, input logic i_sl, input logic i_sr,
                        input logic i_st, input logic [3:0] i_cnt,
                        input logic [7:0] eq, input logic eb, input logic ed,
                        input string nm);
        exp_t e;
        @(negedge clk);
        #2;
        en = i_en; rst_n = i_rst; mode = i_mode; d = i_d;
        sinl = i_sl; sinr = i_sr; start = i_st; count = i_cnt;
        e.chk = 1'b1; e.q = eq; e.busy = eb; e.done = ed; e.nm = nm;
        exp_q.push_back(e);
    endtask

    logic [7:0] long_tab [8];
    logic [7:0] stall_tab [4];

    initial begin
`ifdef USR_ROTATE_EN
        long_tab  = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        stall_tab = '{8'h4B, 8'hA5, 8'hD2, 8'h69};
`else
        long_tab  = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
        stall_tab = '{8'hCB, 8'hE5, 8'hF2, 8'hF9};
`endif
        en = 1'b0; rst_n = 1'b0; mode = 2'b00; d = 8'h00;
        sinl = 1'b0; sinr = 1'b0; start = 1'b0; count = 4'd0;

        // Reset and manual modes
        step(1, 0, 2'b00, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, "rst_init");
        step(1, 1, 2'b11, 8'hA5, 0, 0, 0, 0, 8'hA5, 0, 0, "load_a5");
        step(0, 0, 2'b11, 8'hFF, 0, 0, 0, 0, 8'h00, 0, 0, "rst_over_en");
        step(1, 1, 2'b11, 8'h96, 0, 0, 0, 0, 8'h96, 0, 0, "load_96");
        step(1, 1, 2'b01, 8'h00, 1, 0, 0, 0, 8'hCB, 0, 0, "shr_sinl1");
        step(1, 1, 2'b10, 8'h00, 0, 0, 0, 0, 8'h96, 0, 0, "shl_sinr0");
        for (int i = 0; i < 3; i++)
            step(1, 1, 2'b00, 8'hFF, 1, 1, 0, 0, 8'h96, 0, 0, "hold");
        step(0, 1, 2'b11, 8'h00, 0, 0, 0, 0, 8'h96, 0, 0, "en0_no_load");

        // Burst of 3, with Start and Mode=load applied while busy
        step(1, 1, 2'b11, 8'hF0, 0, 0, 0, 0, 8'hF0, 0, 0, "load_f0");
        step(1, 1, 2'b00, 8'h00, 0, 0, 1, 3, 8'hF0, 1, 0, "burst_start");
        step(1, 1, 2'b11, 8'hFF, 0, 0, 1, 3, 8'h78, 1, 0, "burst_s1");
        step(1, 1, 2'b11, 8'hFF, 0, 0, 1, 3, 8'h3C, 1, 0, "burst_s2");
        step(1, 1, 2'b11, 8'hFF, 0, 0, 1, 3, 8'h1E, 0, 1, "burst_done");
        step(1, 1, 2'b11, 8'hFF, 0, 0, 1, 3, 8'h1E, 0, 0, "done_ignores_mode");
        step(1, 1, 2'b00, 8'h00, 0, 0, 0, 0, 8'h1E, 0, 0, "no_extra_done");

        // Count = 0
        step(1, 1, 2'b11, 8'h00, 0, 0, 1, 0, 8'h1E, 0, 1, "cnt0_done");
        step(1, 1, 2'b00, 8'h00, 0, 0, 0, 0, 8'h1E, 0, 0, "cnt0_after");

        // Count = WIDTH
        step(1, 1, 2'b11, 8'h01, 0, 0, 0, 0, 8'h01, 0, 0, "load_01");
        step(1, 1, 2'b00, 8'h00, 1, 0, 1, 8, 8'h01, 1, 0, "full_start");
        for (int k = 0; k < 8; k++)
            step(1, 1, 2'b00, 8'h00, 1, 0, 0, 0, long_tab[k], (k < 7), (k == 7), "full_shift");
        step(1, 1, 2'b00, 8'h00, 1, 0, 0, 0, long_tab[7], 0, 0, "full_after");

        // Count = 1
        step(1, 1, 2'b11, 8'h01, 0, 0, 0, 0, 8'h01, 0, 0, "load_01b");
        step(1, 1, 2'b00, 8'h00, 1, 0, 1, 1, 8'h01, 1, 0, "one_start");
        step(1, 1, 2'b00, 8'h00, 1, 0, 0, 0, 8'h80, 0, 1, "one_done");
        step(1, 1, 2'b00, 8'h00, 1, 0, 0, 0, 8'h80, 0, 0, "one_after");

        // Stall for two cycles mid-burst, then stall while Done is high
        step(1, 1, 2'b11, 8'h96, 0, 0, 0, 0, 8'h96, 0, 0, "load_96b");
        step(1, 1, 2'b00, 8'h00, 1, 0, 1, 4, 8'h96, 1, 0, "stall_start");
        step(1, 1, 2'b00, 8'h00, 1, 0, 0, 0, stall_tab[0], 1, 0, "stall_s1");
        step(0, 1, 2'b11, 8'h00, 1, 0, 0, 0, stall_tab[0], 1, 0, "stall_hold1");
        step(0, 1, 2'b11, 8'h00, 1, 0, 0, 0, stall_tab[0], 1, 0, "stall_hold2");
        step(1, 1, 2'b00, 8'h00, 1, 0, 0, 0, stall_tab[1], 1, 0, "stall_s2");
        step(1, 1, 2'b00, 8'h00, 1, 0, 0, 0, stall_tab[2], 1, 0, "stall_s3");
        step(1, 1, 2'b00, 8'h00, 1, 0, 0, 0, stall_tab[3], 0, 1, "stall_done");
        step(0, 1, 2'b00, 8'h00, 1, 0, 0, 0, stall_tab[3], 0, 1, "done_held");
        step(1, 1, 2'b00, 8'h00, 1, 0, 0, 0, stall_tab[3], 0, 0, "done_release");

        // Reset mid-burst
        step(1, 1, 2'b11, 8'h96, 0, 0, 0, 0, 8'h96, 0, 0, "load_96c");
        step(1, 1, 2'b00, 8'h00, 0, 0, 1, 3, 8'h96, 1, 0, "abort_start");
        step(1, 1, 2'b00, 8'h00, 0, 0, 0, 0, 8'h4B, 1, 0, "abort_s1");
        step(1, 0, 2'b00, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, "abort_rst");
        step(1, 1, 2'b00, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, "abort_no_done");
        step(1, 1, 2'b10, 8'h00, 0, 1, 0, 0, 8'h01, 0, 0, "post_abort_shl");

        @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register built from D flip-flops. It supports hold, shift-right, shift-left and parallel load under a mode input. It also has an autonomous burst mode that performs N right-shifts from a single Start pulse and then reports completion. It is the general-purpose successor to the single-bit positive-edge D flip-flop in the digital parts library, and is used for serialisers, deserialisers and delay taps.

## Interface
Parameters:
- WIDTH, 8, register width in bits; must be ≥ 2.
- CNT_W, $clog2(WIDTH)+1, width of the burst count; must hold values 0..WIDTH.

Ports:
- Clk  in  1  rising-edge clock, the only clock.
- _Reset  in  1  reset, synchronous, active-low.
- En  in  1  global enable; when 0, Q, the burst counter and the FSM all hold.
- Mode  in  2  manual operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- D  in  WIDTH  parallel load data.
- SinL  in  1  serial input entering at the MSB on right shift.
- SinR  in  1  serial input entering at the LSB on left shift.
- Start  in  1  burst request; sampled only in IDLE.
- Count  in  CNT_W  number of right shifts in the burst.
- Q  out  WIDTH  register contents.
- SoutR  out  1  equals Q[0].
- SoutL  out  1  equals Q[WIDTH-1].
- Busy  out  1  high while in BURST state.
- Done  out  1  one-cycle pulse marking the end of a burst.

## Operation
- Right shift: Q ← {SinL, Q[WIDTH-1:1]}. Left shift: Q ← {Q[WIDTH-2:0], SinR}. Load: Q ← D.
- The FSM has three states: IDLE, BURST, DONE. All outputs and state are registered.
- IDLE:
  - Mode is applied on every enabled edge.
  - If Start=1 and Count≠0: load the counter with Count and go to BURST. Mode is ignored on that edge.
  - If Start=1 and Count=0: go straight to DONE with no shift.
- BURST:
  - Each enabled edge performs one right shift and decrements the counter.
  - When the counter reaches 0, go to DONE.
  - Mode and Start are ignored.
- DONE: Done=1 for one cycle, then go to IDLE unconditionally. Mode is ignored in DONE.
- Count>WIDTH is not legal (CNT_W is sized for 0..WIDTH). A burst of Count=WIDTH fully replaces Q with serial input.
- En=0 freezes everything, including the DONE→IDLE transition. Done then stays high until En returns to 1.
- Reset (_Reset=0 at an edge) sets Q=0, Busy=0, Done=0, counter=0 and state IDLE. Reset mid-burst aborts the burst without a Done pulse.
- Reset has priority over En.

## Timing
- Manual operations take effect at the sampling edge, so Q updates one cycle after the Mode is presented.
- For a burst with Start sampled at edge E, Count=N≥1, and En held at 1:
  - Q shifts at edges E+1 through E+N.
  - Busy is 1 from after edge E through edge E+N.
  - Done is 1 for the single cycle following edge E+N.
  - The next Start is accepted at edge E+N+2 at the earliest.
- For Count=0: Done is 1 for the cycle after edge E, and Busy stays 0.
- SoutL and SoutR are combinational from Q and carry no extra latency.
- Each stalled cycle (En=0) extends all of the above by one cycle.

## Configuration
- USR_ROTATE_EN defined: burst shifts rotate, Q ← {Q[0], Q[WIDTH-1:1]}, and SinL is ignored during BURST.
- USR_ROTATE_EN not defined: burst shifts fill from SinL.
- Manual modes behave identically either way.

## Structure
- Package usr_pkg holds:
  - the mode encoding constants: MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD;
  - the FSM state typedef: IDLE, BURST, DONE.
- Sub-module usr_burst_fsm holds the state register, down-counter, Busy and Done. It outputs a shift-right strobe and a mode-override signal to the datapath.
- The top level holds the WIDTH-bit register and the next-value mux.

## Test plan
All scenarios use WIDTH=8.
- Reset: drive _Reset=0 for 1 edge with Q previously 8'hA5 → Q=8'h00, Busy=0, Done=0 after that edge.
- Manual modes:
  - Load D=8'h96, then shift right with SinL=1 → Q=8'hCB.
  - Then shift left with SinR=0 → Q=8'h96.
  - Then hold 3 cycles → Q stays 8'h96, with SoutL=1 and SoutR=0.
- Burst fill, no USR_ROTATE_EN: Q=8'hF0, SinL=0, Start with Count=3 → Q=8'h1E after 3 shifts, Busy high for 3 cycles, Done high for exactly 1 cycle after that.
- Burst rotate, USR_ROTATE_EN defined: Q=8'h01, Count=8 → Q=8'h01 at Done. Same Q=8'h01 with Count=1 → Q=8'h80.
- Edge cases:
  - Count=0 → Done the cycle after Start, Busy never asserted, Q unchanged.
  - Start while Busy → ignored, with no extra Done.
  - Mode=11 during BURST → no load.
- Stall and reset:
  - En=0 for 2 cycles mid-burst (Count=4) → Done arrives 2 cycles later and Q is correct.
  - _Reset=0 mid-burst → IDLE, Q=0, no Done.
